// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the ROM combinationally and fills the IF/ID register.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_stage #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] rom_addr,
   input  logic [31:0] rom_data,
   output logic [31:0] pc_f,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic [31:0] pc_plus4_d,
   output logic        valid_d,
`ifdef FETCH_MISALIGN_CHECK_EN
   output logic        misalign_err,
`endif
   output logic [31:0] fetch_cnt
);

   logic [31:0] fpc_q,      fpc_d;
   logic [31:0] id_instr_q, id_instr_d;
   logic [31:0] id_pc_q,    id_pc_d;
   logic [31:0] id_pc4_q,   id_pc4_d;
   logic        id_valid_q, id_valid_d;
   logic [31:0] cnt_q,      cnt_d;
   logic [31:0] fpc_plus4;
   logic [31:0] redir_target;

   assign fpc_plus4 = fpc_q + 32'd4;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic err_q, err_d;
   logic redir_bad;

   // A misaligned target is never fetched; the core restarts from the reset vector instead.
   assign redir_bad    = |redirect_pc[1:0];
   assign redir_target = redir_bad ? RESET_VECTOR : redirect_pc;
   assign misalign_err = err_q;

   always_comb begin
      err_d = err_q;
      if (redirect && redir_bad) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end
`else
   assign redir_target = redirect_pc;
`endif

   always_comb begin
      fpc_d      = fpc_q;
      id_instr_d = id_instr_q;
      id_pc_d    = id_pc_q;
      id_pc4_d   = id_pc4_q;
      id_valid_d = id_valid_q;
      cnt_d      = cnt_q;
      if (redirect) begin
         // Squash the word fetched this cycle; pc_d/pc_plus4_d keep their last values.
         fpc_d      = redir_target;
         id_instr_d = NOP_INSTR;
         id_valid_d = 1'b0;
      end else if (!stall) begin
         fpc_d      = fpc_plus4;
         id_instr_d = rom_data;
         id_pc_d    = fpc_q;
         id_pc4_d   = fpc_plus4;
         id_valid_d = 1'b1;
         cnt_d      = cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fpc_q      <= RESET_VECTOR;
         id_instr_q <= NOP_INSTR;
         id_pc_q    <= 32'd0;
         id_pc4_q   <= 32'd0;
         id_valid_q <= 1'b0;
         cnt_q      <= 32'd0;
      end else begin
         fpc_q      <= fpc_d;
         id_instr_q <= id_instr_d;
         id_pc_q    <= id_pc_d;
         id_pc4_q   <= id_pc4_d;
         id_valid_q <= id_valid_d;
         cnt_q      <= cnt_d;
      end
   end

   assign rom_addr   = fpc_q;
   assign pc_f       = fpc_q;
   assign instr_d    = id_instr_q;
   assign pc_d       = id_pc_q;
   assign pc_plus4_d = id_pc4_q;
   assign valid_d    = id_valid_q;
   assign fetch_cnt  = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run against a behavioural model.
// Build with FETCH_MISALIGN_CHECK_EN defined to exercise the misaligned-redirect trap.
module tb_fetch_stage;

   localparam logic [31:0] RV  = 32'h0000_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic [31:0] rom_addr, rom_data, pc_f, instr_d, pc_d, pc_plus4_d, fetch_cnt;
   logic        valid_d;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic        misalign_err;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state
   logic [31:0] m_pc, m_instr, m_pcd, m_pc4, m_cnt;
   logic        m_valid, m_err;

   always #5 clk = ~clk;

   // Word-addressed ROM: low two address bits ignored.
   function automatic logic [31:0] rom_word(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      return (w * 32'h9E37_79B1) ^ 32'hA5A5_0013;
   endfunction

   assign rom_data = rom_word(rom_addr);

   fetch_stage #(.RESET_VECTOR(RV), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .rom_addr(rom_addr), .rom_data(rom_data),
      .pc_f(pc_f), .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
      .valid_d(valid_d),
`ifdef FETCH_MISALIGN_CHECK_EN
      .misalign_err(misalign_err),
`endif
      .fetch_cnt(fetch_cnt)
   );

   // Apply one clock edge to the model using the current inputs, then to the DUT.
   task automatic tick();
      logic misal;
      misal = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misal = (redirect_pc[1:0] != 2'b00);
`endif
      if (!rst_n) begin
         m_pc = RV; m_instr = NOP; m_pcd = 0; m_pc4 = 0; m_valid = 0; m_cnt = 0; m_err = 0;
      end else if (redirect) begin
         m_pc    = misal ? RV : redirect_pc;
         m_err   = m_err | misal;
         m_instr = NOP;
         m_valid = 0;
      end else if (!stall) begin
         m_instr = rom_word(m_pc);
         m_pcd   = m_pc;
         m_pc4   = m_pc + 4;
         m_pc    = m_pc + 4;
         m_valid = 1;
         m_cnt   = m_cnt + 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
      rst_n = r; stall = s; redirect = rd; redirect_pc = rpc;
   endtask

   task automatic test_reset();
      drive(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom);
      tick();
      n_checks++; if (pc_f !== RV) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", pc_f, RV); end
      n_checks++; if (rom_addr !== RV) begin n_fail++; $display("FAIL reset_rom_addr got=%h exp=%h", rom_addr, RV); end
      n_checks++; if (instr_d !== NOP) begin n_fail++; $display("FAIL reset_instr got=%h exp=%h", instr_d, NOP); end
      n_checks++; if (valid_d !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid_d); end
      n_checks++; if (fetch_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", fetch_cnt); end
      n_checks++; if (pc_d !== 32'd0 || pc_plus4_d !== 32'd0) begin n_fail++; $display("FAIL reset_pcd got=%h/%h exp=0/0", pc_d, pc_plus4_d); end
`ifdef FETCH_MISALIGN_CHECK_EN
      n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", misalign_err); end
`endif
   endtask

   task automatic test_sequential();
      drive(0, 0, 0, 0); tick();
      drive(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (rom_addr !== 32'(i * 4)) begin n_fail++; $display("FAIL seq_rom_addr[%0d] got=%h exp=%h", i, rom_addr, i * 4); end
         tick();
         n_checks++; if (instr_d !== rom_word(32'(i * 4)) || pc_d !== 32'(i * 4) || valid_d !== 1'b1)
            begin n_fail++; $display("FAIL seq_ifid[%0d] got=%h/%h/%b exp=%h/%h/1", i, instr_d, pc_d, valid_d, rom_word(32'(i * 4)), i * 4); end
      end
      n_checks++; if (rom_addr !== 32'hC) begin n_fail++; $display("FAIL seq_rom_addr[3] got=%h exp=c", rom_addr); end
      n_checks++; if (fetch_cnt !== 32'd3) begin n_fail++; $display("FAIL seq_cnt got=%0d exp=3", fetch_cnt); end
   endtask

   task automatic test_stall();
      drive(0, 0, 0, 0); tick();
      drive(1, 0, 0, 0); tick(); tick();
      drive(1, 1, 0, 0);
      for (int i = 0; i < 2; i++) begin
         tick();
         n_checks++; if (pc_f !== 32'h8 || instr_d !== rom_word(32'h4) || pc_d !== 32'h4 || fetch_cnt !== 32'd2)
            begin n_fail++; $display("FAIL stall_hold[%0d] got pc=%h instr=%h pcd=%h cnt=%0d", i, pc_f, instr_d, pc_d, fetch_cnt); end
      end
      drive(1, 0, 0, 0); tick();
      n_checks++; if (instr_d !== rom_word(32'h8) || pc_d !== 32'h8 || fetch_cnt !== 32'd3)
         begin n_fail++; $display("FAIL stall_release got instr=%h pcd=%h cnt=%0d exp=%h/8/3", instr_d, pc_d, fetch_cnt, rom_word(32'h8)); end
   endtask

   task automatic test_redirect();
      logic [31:0] cnt0;
      cnt0 = fetch_cnt;
      drive(1, 1, 1, 32'h40); tick();
      n_checks++; if (pc_f !== 32'h40 || valid_d !== 1'b0 || instr_d !== NOP || fetch_cnt !== cnt0)
         begin n_fail++; $display("FAIL redir_bubble got pc=%h v=%b instr=%h cnt=%0d", pc_f, valid_d, instr_d, fetch_cnt); end
      n_checks++; if (pc_d !== 32'h8 || pc_plus4_d !== 32'hC)
         begin n_fail++; $display("FAIL redir_pcd_hold got=%h/%h exp=8/c", pc_d, pc_plus4_d); end
      drive(1, 0, 0, 0); tick();
      n_checks++; if (instr_d !== rom_word(32'h40) || pc_d !== 32'h40 || pc_plus4_d !== 32'h44 || valid_d !== 1'b1)
         begin n_fail++; $display("FAIL redir_target got instr=%h pcd=%h pc4=%h v=%b", instr_d, pc_d, pc_plus4_d, valid_d); end
   endtask

   task automatic test_back_to_back();
      drive(1, 0, 1, 32'h100); tick();
      drive(1, 0, 1, 32'h200); tick();
      n_checks++; if (pc_f !== 32'h200 || valid_d !== 1'b0)
         begin n_fail++; $display("FAIL b2b_redir got pc=%h v=%b exp=200/0", pc_f, valid_d); end
      drive(1, 0, 0, 0); tick();
      n_checks++; if (valid_d !== 1'b1 || pc_d !== 32'h200 || instr_d !== rom_word(32'h200))
         begin n_fail++; $display("FAIL b2b_resume got v=%b pcd=%h instr=%h", valid_d, pc_d, instr_d); end
   endtask

   task automatic test_wrap();
      drive(1, 0, 1, 32'hFFFF_FFFC); tick();
      drive(1, 0, 0, 0); tick();
      n_checks++; if (pc_f !== 32'h0 || pc_plus4_d !== 32'h0 || pc_d !== 32'hFFFF_FFFC)
         begin n_fail++; $display("FAIL wrap got pc=%h pc4=%h pcd=%h exp=0/0/fffffffc", pc_f, pc_plus4_d, pc_d); end
   endtask

   task automatic test_reset_during_redirect();
      drive(1, 0, 0, 0); tick(); tick();
      drive(0, 0, 1, 32'h80); tick();
      n_checks++; if (pc_f !== RV || fetch_cnt !== 32'd0 || valid_d !== 1'b0)
         begin n_fail++; $display("FAIL rst_redir got pc=%h cnt=%0d v=%b", pc_f, fetch_cnt, valid_d); end
      drive(1, 0, 0, 0);
   endtask

   task automatic test_misalign();
      drive(1, 0, 1, 32'h42); tick();
`ifdef FETCH_MISALIGN_CHECK_EN
      n_checks++; if (misalign_err !== 1'b1 || pc_f !== RV || valid_d !== 1'b0)
         begin n_fail++; $display("FAIL misal_trap got err=%b pc=%h v=%b", misalign_err, pc_f, valid_d); end
      drive(1, 0, 0, 0);
      for (int i = 0; i < 10; i++) tick();
      n_checks++; if (misalign_err !== 1'b1 || pc_f !== 32'(RV + 40))
         begin n_fail++; $display("FAIL misal_sticky got err=%b pc=%h", misalign_err, pc_f); end
      drive(0, 0, 0, 0); tick();
      n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL misal_clear got=%b exp=0", misalign_err); end
`else
      n_checks++; if (pc_f !== 32'h42 || rom_addr !== 32'h42)
         begin n_fail++; $display("FAIL misal_load got pc=%h addr=%h exp=42", pc_f, rom_addr); end
      drive(1, 0, 0, 0); tick();
      n_checks++; if (instr_d !== rom_word(32'h40) || pc_d !== 32'h42 || pc_plus4_d !== 32'h46 || pc_f !== 32'h46)
         begin n_fail++; $display("FAIL misal_fetch got instr=%h pcd=%h pc4=%h pc=%h", instr_d, pc_d, pc_plus4_d, pc_f); end
`endif
      drive(1, 0, 0, 0);
   endtask

   task automatic test_random();
      int errs;
      errs = 0;
      for (int i = 0; i < 400; i++) begin
         logic [31:0] tgt;
         case ($urandom_range(0, 9))
            0:       tgt = 32'hFFFF_FFFC;
            1:       tgt = $urandom;
            default: tgt = {$urandom_range(0, 32'h3FF), 2'b00};
         endcase
         drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), tgt);
         tick();
         n_checks++;
         if (pc_f !== m_pc || rom_addr !== m_pc || instr_d !== m_instr || pc_d !== m_pcd ||
             pc_plus4_d !== m_pc4 || valid_d !== m_valid || fetch_cnt !== m_cnt
`ifdef FETCH_MISALIGN_CHECK_EN
             || misalign_err !== m_err
`endif
            ) begin
            n_fail++;
            if (errs < 10)
               $display("FAIL random[%0d] got pc=%h instr=%h pcd=%h pc4=%h v=%b cnt=%0d exp pc=%h instr=%h pcd=%h pc4=%h v=%b cnt=%0d",
                        i, pc_f, instr_d, pc_d, pc_plus4_d, valid_d, fetch_cnt, m_pc, m_instr, m_pcd, m_pc4, m_valid, m_cnt);
            errs++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_redirect();
      test_back_to_back();
      test_wrap();
      test_reset_during_redirect();
      test_misalign();
      test_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
